// File: rtl/fns_decoder_7_2_pkg.sv
// Shared constants and FSM encoding for the FNS (Fibonacci numeral system) TSV
// decoder and its weight generator.
package fns_decoder_7_2_pkg;

   localparam int DEF_NTSV  = 9;   // 7 data TSVs + 2 redundant
   localparam int DEF_NDATA = 7;   // healthy TSVs needed for a valid configuration
   localparam int WW        = 6;   // weight width
   localparam int DW        = 6;   // decoded data width (max sum 53)
   localparam int SPLIT     = 5;   // stage-1 partial sums: TSV0..4 and TSV5..8

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RUN  = 2'd2
   } fsm_state_t;

endpackage

// File: rtl/fns_weight_gen.sv
// CALC sequencer: walks the TSVs one per cycle and gives each healthy TSV the
// next Fibonacci weight until NDATA TSVs are enabled.
module fns_weight_gen
   import fns_decoder_7_2_pkg::*;
#(
   parameter int NTSV  = DEF_NTSV,
   parameter int NDATA = DEF_NDATA
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_valid,
   input  logic [NTSV-1:0]           f_flag,
   output logic [NTSV-1:0][WW-1:0]   weights,
   output logic [NTSV-1:0]           en_flag,
   output logic                      cfg_done,
   output logic                      cfg_err
);

   localparam int IW = $clog2(NTSV);
   localparam int UW = $clog2(NDATA + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NTSV - 1);
   localparam logic [UW-1:0] USED_MAX = UW'(NDATA);

   fsm_state_t                state_q, state_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [WW-1:0]             prev2_q, prev2_d;
   logic [WW-1:0]             prev1_q, prev1_d;
   logic [WW-1:0]             w_new;
   logic [UW-1:0]             used_q, used_d;
   logic [NTSV-1:0]           f_q, f_d;
   logic [NTSV-1:0]           en_q, en_d;
   logic [NTSV-1:0][WW-1:0]   w_q, w_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;

   assign w_new = prev2_q + prev1_q;

   always_comb begin
      // NOTE: every _d starts as its _q so no path through this block infers a latch.
      state_d = state_q;
      idx_d   = idx_q;
      prev2_d = prev2_q;
      prev1_d = prev1_q;
      used_d  = used_q;
      f_d     = f_q;
      en_d    = en_q;
      w_d     = w_q;
      done_d  = done_q;
      err_d   = err_q;

      if (state_q == CALC) begin
         if (!f_q[idx_q] && (used_q < USED_MAX)) begin
            w_d[idx_q]  = w_new;
            en_d[idx_q] = 1'b1;
            prev2_d     = prev1_q;
            prev1_d     = w_new;
            used_d      = used_q + UW'(1);
         end else begin
            w_d[idx_q]  = '0;
            en_d[idx_q] = 1'b0;
         end

         if (idx_q == LAST_IDX) begin
            if (used_d == USED_MAX) begin
               state_d = RUN;
               done_d  = 1'b1;
            end else begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end

      // A new configuration request overrides whatever the FSM was doing.
      if (cfg_valid) begin
         state_d = CALC;
         idx_d   = '0;
         prev2_d = '0;
         prev1_d = WW'(1);
         used_d  = '0;
         f_d     = f_flag;
         en_d    = '0;
         w_d     = '0;
         done_d  = 1'b0;
         err_d   = 1'b0;
      end
   end

   // NOTE: the weight table is reset with the FSM so an aborted CALC leaves no stale weights.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         prev2_q <= '0;
         prev1_q <= '0;
         used_q  <= '0;
         f_q     <= '0;
         en_q    <= '0;
         w_q     <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         prev2_q <= prev2_d;
         prev1_q <= prev1_d;
         used_q  <= used_d;
         f_q     <= f_d;
         en_q    <= en_d;
         w_q     <= w_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign weights  = w_q;
   assign en_flag  = en_q;
   assign cfg_done = done_q;
   assign cfg_err  = err_q;

endmodule

// File: rtl/fns_decoder_7_2.sv
// FNS TSV decoder: weight generator plus a 2-stage ready/valid pipeline that
// sums the weights of the enabled TSVs carrying a 1.
module fns_decoder_7_2
   import fns_decoder_7_2_pkg::*;
#(
   parameter int NTSV  = DEF_NTSV,
   parameter int NDATA = DEF_NDATA
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   input  logic [NTSV-1:0]   f_flag,
   output logic              cfg_done,
   output logic              cfg_err,
   output logic [NTSV-1:0]   en_flag,
   input  logic              cw_valid,
   input  logic [NTSV-1:0]   cw,
   output logic              cw_ready,
   output logic              data_valid,
   output logic [DW-1:0]     data,
   input  logic              data_ready,
   output logic              cw_err
);

   logic [NTSV-1:0][WW-1:0] w;

   fns_weight_gen #(
      .NTSV  (NTSV),
      .NDATA (NDATA)
   ) u_weight_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .f_flag    (f_flag),
      .weights   (w),
      .en_flag   (en_flag),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err)
   );

   logic          s1_valid_q, s1_valid_d;
   logic [DW-1:0] s1_lo_q, s1_lo_d;
   logic [DW-1:0] s1_hi_q, s1_hi_d;
   logic          s1_err_q, s1_err_d;
   logic          s2_valid_q, s2_valid_d;
   logic [DW-1:0] data_q, data_d;
   logic          cw_err_q, cw_err_d;

   logic          adv1, adv2, accept;
   logic [DW-1:0] lo_sum, hi_sum;

   // cfg_done is high exactly while the weight generator sits in RUN.
   assign adv2     = !s2_valid_q || data_ready;
   assign adv1     = !s1_valid_q || adv2;
   assign cw_ready = cfg_done && adv1;
   assign accept   = cw_valid && cw_ready;

   always_comb begin
      lo_sum = '0;
      hi_sum = '0;
      for (int i = 0; i < NTSV; i++) begin
         if (cw[i] && en_flag[i]) begin
            if (i < SPLIT) lo_sum = lo_sum + DW'(w[i]);
            else           hi_sum = hi_sum + DW'(w[i]);
         end
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_lo_d    = s1_lo_q;
      s1_hi_d    = s1_hi_q;
      s1_err_d   = s1_err_q;
      s2_valid_d = s2_valid_q;
      data_d     = data_q;
      cw_err_d   = cw_err_q;

      if (adv1) begin
         s1_valid_d = accept;
         if (accept) begin
            s1_lo_d  = lo_sum;
            s1_hi_d  = hi_sum;
            s1_err_d = |(cw & ~en_flag);
         end
      end

      if (adv2) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            data_d   = s1_lo_q + s1_hi_q;
            cw_err_d = s1_err_q;
         end
      end

      if (cfg_valid) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_lo_q    <= '0;
         s1_hi_q    <= '0;
         s1_err_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         data_q     <= '0;
         cw_err_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_lo_q    <= s1_lo_d;
         s1_hi_q    <= s1_hi_d;
         s1_err_q   <= s1_err_d;
         s2_valid_q <= s2_valid_d;
         data_q     <= data_d;
         cw_err_q   <= cw_err_d;
      end
   end

   assign data_valid = s2_valid_q;
   assign data       = data_q;
   assign cw_err     = cw_err_q;

endmodule

// File: tb/tb_fns_decoder_7_2.sv
// Self-checking bench for fns_decoder_7_2: directed scenarios plus randomized
// configurations and codeword streams against a Fibonacci-table reference model.
module tb_fns_decoder_7_2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic [8:0] f_flag;
  logic       cfg_done, cfg_err;
  logic [8:0] en_flag;
  logic       cw_valid;
  logic [8:0] cw;
  logic       cw_ready;
  logic       data_valid;
  logic [5:0] data;
  logic       data_ready;
  logic       cw_err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: weight per TSV, enable mask, configuration outcome.
  int         m_w [9];
  logic [8:0] m_en;
  bit         m_ok;

  always #5 clk = ~clk;

  fns_decoder_7_2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .f_flag     (f_flag),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .en_flag    (en_flag),
    .cw_valid   (cw_valid),
    .cw         (cw),
    .cw_ready   (cw_ready),
    .data_valid (data_valid),
    .data       (data),
    .data_ready (data_ready),
    .cw_err     (cw_err)
  );

  // The k-th healthy TSV (k < 7) gets the k-th term of 1,2,3,5,8,13,21.
  function automatic void model_config(input logic [8:0] f);
    int fib [7] = '{1, 2, 3, 5, 8, 13, 21};
    int k = 0;
    m_en = '0;
    for (int i = 0; i < 9; i++) begin
      m_w[i] = 0;
      if (!f[i] && k < 7) begin
        m_w[i]  = fib[k];
        m_en[i] = 1'b1;
        k++;
      end
    end
    m_ok = (k == 7);
  endfunction

  function automatic logic [5:0] model_data(input logic [8:0] c);
    int s = 0;
    for (int i = 0; i < 9; i++) if (c[i] && m_en[i]) s += m_w[i];
    return 6'(s);
  endfunction

  function automatic logic model_err(input logic [8:0] c);
    return |(c & ~m_en);
  endfunction

  task automatic run_config(input logic [8:0] f);
    model_config(f);
    @(negedge clk);
    cfg_valid = 1'b1;
    f_flag    = f;
    @(negedge clk);
    cfg_valid  = 1'b0;
    f_flag     = 9'($urandom);
    data_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (cfg_done !== 1'b0 || cfg_err !== 1'b0 || cw_ready !== 1'b0 || data_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL calc_cycle%0d f=%h: done=%b err=%b rdy=%b dv=%b expected all 0",
                 k, f, cfg_done, cfg_err, cw_ready, data_valid);
      end
      @(negedge clk);
    end
    vectors++;
    if (cfg_done !== m_ok || cfg_err !== !m_ok || en_flag !== m_en || cw_ready !== m_ok) begin
      miscompares++;
      $display("FAIL cfg_result f=%h: done=%b err=%b en=%h rdy=%b expected done=%b err=%b en=%h rdy=%b",
               f, cfg_done, cfg_err, en_flag, cw_ready, m_ok, !m_ok, m_en, m_ok);
    end
  endtask

  // One codeword into an empty pipeline: exact 2-cycle latency, then drained.
  task automatic send_one(input logic [8:0] c, input logic [5:0] exp_d, input logic exp_e,
                          input string tag);
    cw_valid   = 1'b1;
    cw         = c;
    data_ready = 1'b1;
    #1;
    vectors++;
    if (cw_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready: cw_ready=%b expected 1", tag, cw_ready);
    end
    @(negedge clk);
    cw_valid = 1'b0;
    cw       = 9'($urandom);
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_early: data_valid=%b expected 0 one cycle after accept", tag, data_valid);
    end
    @(negedge clk);
    vectors++;
    if (data_valid !== 1'b1 || data !== exp_d || cw_err !== exp_e) begin
      miscompares++;
      $display("FAIL %s: dv=%b data=%0d cw_err=%b expected dv=1 data=%0d cw_err=%b",
               tag, data_valid, data, cw_err, exp_d, exp_e);
    end
    @(negedge clk);
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_dup: data_valid=%b expected 0 after consume", tag, data_valid);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if ({cfg_done, cfg_err, cw_ready, data_valid, cw_err} !== 5'b0 || en_flag !== 9'h0 || data !== 6'h0) begin
      miscompares++;
      $display("FAIL %s: done=%b err=%b rdy=%b dv=%b cw_err=%b en=%h data=%0d expected all 0",
               tag, cfg_done, cfg_err, cw_ready, data_valid, cw_err, en_flag, data);
    end
  endtask

  task automatic test_reset;
    #3;
    check_reset_outputs("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_reset_outputs("post_reset_idle");
    end
  endtask

  task automatic test_zero_fault;
    run_config(9'h000);
    vectors++;
    if (en_flag !== 9'h07F || cfg_done !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_fault_cfg: en=%h done=%b expected en=07f done=1", en_flag, cfg_done);
    end
    send_one(9'h055, 6'd33, 1'b0, "cw_055");
  endtask

  task automatic test_one_fault;
    int exp_w [9] = '{1, 2, 0, 3, 5, 8, 13, 21, 0};
    run_config(9'h004);
    vectors++;
    if (en_flag !== 9'h0FB) begin
      miscompares++;
      $display("FAIL one_fault_en: en=%h expected 0fb", en_flag);
    end
    send_one(9'h080, 6'd21, 1'b0, "cw_080");
    for (int i = 0; i < 9; i++) begin
      logic [8:0] c;
      c = 9'h0;
      c[i] = 1'b1;
      send_one(c, 6'(exp_w[i]), (i == 2 || i == 8), $sformatf("weight_tsv%0d", i));
    end
  endtask

  task automatic test_cw_err;
    run_config(9'h000);
    send_one(9'h100, 6'd0, 1'b1, "cw_100");
    send_one(9'h07F, 6'd53, 1'b0, "cw_max");
    send_one(9'h1FF, 6'd53, 1'b1, "cw_all_ones");
  endtask

  task automatic test_cfg_err;
    run_config(9'h109);
    vectors++;
    if (cfg_err !== 1'b1 || cfg_done !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_err_109: err=%b done=%b expected err=1 done=0", cfg_err, cfg_done);
    end
    cw_valid = 1'b1;
    cw       = 9'h055;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (cw_ready !== 1'b0 || data_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL cfg_err_blocked: rdy=%b dv=%b expected 0 0", cw_ready, data_valid);
      end
      @(negedge clk);
    end
    cw_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [8:0] a, b, c;
    logic [5:0] ea, eb, ec;
    logic       ra;
    run_config(9'h000);
    a = 9'($urandom); b = 9'($urandom); c = 9'($urandom);
    ea = model_data(a); eb = model_data(b); ec = model_data(c);
    ra = model_err(a);
    data_ready = 1'b0;
    cw_valid   = 1'b1;
    cw         = a;
    #1;
    vectors++;
    if (cw_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready_a: cw_ready=%b expected 1", cw_ready);
    end
    @(negedge clk);
    cw = b;
    #1;
    vectors++;
    if (cw_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready_b: cw_ready=%b expected 1", cw_ready);
    end
    @(negedge clk);
    cw = c;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (cw_ready !== 1'b0 || data_valid !== 1'b1 || data !== ea || cw_err !== ra) begin
        miscompares++;
        $display("FAIL b2b_stall%0d: rdy=%b dv=%b data=%0d cw_err=%b expected rdy=0 dv=1 data=%0d cw_err=%b",
                 k, cw_ready, data_valid, data, cw_err, ea, ra);
      end
      @(negedge clk);
    end
    data_ready = 1'b1;
    #1;
    vectors++;
    if (cw_ready !== 1'b1 || data !== ea) begin
      miscompares++;
      $display("FAIL b2b_release: rdy=%b data=%0d expected rdy=1 data=%0d", cw_ready, data, ea);
    end
    @(negedge clk);
    cw_valid = 1'b0;
    vectors++;
    if (data_valid !== 1'b1 || data !== eb) begin
      miscompares++;
      $display("FAIL b2b_second: dv=%b data=%0d expected dv=1 data=%0d", data_valid, data, eb);
    end
    @(negedge clk);
    vectors++;
    if (data_valid !== 1'b1 || data !== ec) begin
      miscompares++;
      $display("FAIL b2b_third: dv=%b data=%0d expected dv=1 data=%0d", data_valid, data, ec);
    end
    @(negedge clk);
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drained: dv=%b expected 0", data_valid);
    end
  endtask

  task automatic fill_pipeline;
    data_ready = 1'b0;
    cw_valid   = 1'b1;
    cw         = 9'($urandom);
    @(negedge clk);
    cw = 9'($urandom);
    @(negedge clk);
    cw_valid = 1'b0;
    vectors++;
    if (data_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_pipeline: dv=%b expected 1", data_valid);
    end
  endtask

  task automatic test_flush;
    fill_pipeline();
    run_config(9'h000);
    send_one(9'h055, 6'd33, 1'b0, "after_flush");
  endtask

  task automatic test_reset_mid_op;
    cfg_valid = 1'b1;
    f_flag    = 9'h000;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_calc");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_reset_outputs("no_resume_without_cfg");
    end
    run_config(9'h000);
    fill_pipeline();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_run");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_run_reset");
    run_config(9'h000);
    send_one(9'h055, 6'd33, 1'b0, "resume");
  endtask

  task automatic test_random;
    logic [5:0] exp_data_q [$];
    logic       exp_err_q [$];
    logic [8:0] f;
    for (int r = 0; r < 6; r++) begin
      f = 9'h0;
      if (r == 5) f = 9'($urandom);
      else repeat ($urandom_range(0, 2)) f[$urandom_range(0, 8)] = 1'b1;
      run_config(f);
      if (!m_ok) continue;
      for (int cyc = 0; cyc < 80; cyc++) begin
        logic exp_rdy;
        cw_valid   = ($urandom_range(0, 3) != 0);
        cw         = 9'($urandom);
        data_ready = ($urandom_range(0, 3) != 0);
        #1;
        exp_rdy = (exp_data_q.size() < 2) || data_ready;
        vectors++;
        if (cw_ready !== exp_rdy) begin
          miscompares++;
          $display("FAIL rand_ready cfg%0d cyc%0d: cw_ready=%b expected %b", r, cyc, cw_ready, exp_rdy);
        end
        if (data_valid && data_ready) begin
          vectors++;
          if (exp_data_q.size() == 0) begin
            miscompares++;
            $display("FAIL rand_extra cfg%0d cyc%0d: data=%0d with nothing outstanding", r, cyc, data);
          end else begin
            logic [5:0] ed;
            logic       ee;
            ed = exp_data_q.pop_front();
            ee = exp_err_q.pop_front();
            if (data !== ed || cw_err !== ee) begin
              miscompares++;
              $display("FAIL rand_data cfg%0d cyc%0d: data=%0d cw_err=%b expected data=%0d cw_err=%b",
                       r, cyc, data, cw_err, ed, ee);
            end
          end
        end
        if (cw_valid && cw_ready) begin
          exp_data_q.push_back(model_data(cw));
          exp_err_q.push_back(model_err(cw));
        end
        @(negedge clk);
      end
      cw_valid   = 1'b0;
      data_ready = 1'b1;
      for (int k = 0; k < 10 && exp_data_q.size() > 0; k++) begin
        #1;
        if (data_valid) begin
          logic [5:0] ed;
          logic       ee;
          ed = exp_data_q.pop_front();
          ee = exp_err_q.pop_front();
          vectors++;
          if (data !== ed || cw_err !== ee) begin
            miscompares++;
            $display("FAIL rand_drain cfg%0d: data=%0d cw_err=%b expected data=%0d cw_err=%b",
                     r, data, cw_err, ed, ee);
          end
        end
        @(negedge clk);
      end
      vectors++;
      if (exp_data_q.size() != 0) begin
        miscompares++;
        $display("FAIL rand_lost cfg%0d: %0d results never appeared expected 0", r, exp_data_q.size());
        exp_data_q.delete();
        exp_err_q.delete();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    f_flag     = 9'h0;
    cw_valid   = 1'b0;
    cw         = 9'h0;
    data_ready = 1'b1;
    test_reset();
    test_zero_fault();
    test_one_fault();
    test_cw_err();
    test_cfg_err();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
